glb_stream_src: RTL
===================

// Module: glb_stream_src
// PURPOSE
//  Synthesisable, parametrised GLB-to-fabric stream source for sparse unit tests and on-chip replay.
//  Holds a word image loaded through a config write port. After a flush pulse it streams the
//  image over valid/ready until a word count or a done-token count is reached.
//  Adds width/depth parameters, re-arm on each flush, and LFSR-driven bubble insertion.
// PARAMETERS
//  DATA_WIDTH  17        payload width incl. token bit
//  DEPTH       2048      image words; AW = $clog2(DEPTH)
//  DONE_TOKEN  17'h10100 word value that counts as a done token (DATA_WIDTH wide)
//  STALL_MASK  16'h0003  LFSR bits tested for a bubble; bubble when (lfsr & STALL_MASK)==0
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous active-low reset
//  flush          in   1           start/abort strobe; level, edge-detected internally
//  cfg_wr_en      in   1           image write strobe
//  cfg_wr_addr    in   AW          image write address
//  cfg_wr_data    in   DATA_WIDTH  image write data
//  cfg_tx_size    in   AW+1        max words to send (0..DEPTH)
//  cfg_done_num   in   8           done tokens to send before stopping; 0 = token stop disabled
//  cfg_stall_en   in   1           enable random bubbles
//  cfg_lfsr_seed  in   16          LFSR seed, loaded on flush fall; 0 is replaced by 16'h1
//  data           out  DATA_WIDTH  stream payload
//  valid          out  1           payload valid
//  ready          in   1           sink ready
//  done           out  1           stream finished
//  busy           out  1           state is WAIT or STREAM
// BEHAVIOUR
//  Reset: data=0, valid=0, done=0, busy=0, state=IDLE, counters=0, lfsr=16'h1. Image contents not reset.
//  Image: cfg_wr_en writes mem[cfg_wr_addr] at posedge. Writes are ignored while busy.
//  Config latch: cfg_tx_size, cfg_done_num and cfg_stall_en are latched on flush fall.
//  FSM:
//   IDLE/DONE -> ARMED on flush rise. Entering ARMED clears done.
//   ARMED -> WAIT on flush fall; latch config, load seed, clear counters, wait_cnt=3.
//   WAIT: decrement wait_cnt each cycle; at 0 -> STREAM. If tx_size==0 -> DONE instead.
//   STREAM: first valid appears the cycle after entry, with data=mem[0].
//   STREAM -> DONE after the transfer that makes num_tx==tx_size,
//     or that makes tok_cnt==done_num when done_num!=0.
//   DONE: valid=0, done=1, held until the next flush rise.
//  Handshake:
//   Transfer = valid&&ready at posedge.
//   Once valid=1, data and valid hold until transfer.
//   After a transfer the next word mem[num_tx+1] is presented the next cycle, so throughput is 1 word/clk.
//  Bubbles: when stall_en=1 and no word is pending, lfsr advances every STREAM cycle.
//   LFSR polynomial x^16+x^14+x^13+x^11+1, Galois form.
//   If (lfsr & STALL_MASK)==0, valid stays 0 that cycle. A pending word is never withdrawn.
//  Tokens: a transferred word equal to DONE_TOKEN increments tok_cnt (8b, saturating).
//   A done token still counts in num_tx.
//  Widths: num_tx is AW+1 bits. Address wraps never occur because tx_size<=DEPTH.
//   cfg_tx_size>DEPTH is clamped to DEPTH at latch.
//  Abort: a flush rise in WAIT or STREAM drops valid the next cycle and goes to ARMED;
//   the pending word is discarded.
//  Reset mid-stream: immediate return to reset values; no partial handshake completes.
//  Simultaneous: transfer and terminating condition in one cycle -> DONE next cycle, valid=0.
//   flush rise in the same cycle as the final transfer -> transfer counts, then ARMED.
// TESTING
//  T1 Basic: load 8 words 0..7, tx=8, done_num=0, ready=1, flush pulse
//     -> valid 4 clks after flush fall; 0..7 on consecutive clks; done=1 next clk.
//  T2 Token stop: image {1,2,10100,3,10100,4}, tx=6, done_num=2
//     -> 5 words sent (ending with the 2nd 10100), word 4 never valid, done=1.
//  T3 Backpressure: ready toggles 1010..., tx=4
//     -> each word held stable until ready=1; exactly 4 transfers in order.
//  T4 Bubbles: stall_en=1, seed=16'hACE1, tx=64, ready=1
//     -> 64 words in order, >=1 idle cycle, valid never drops before a transfer.
//  T5 Abort/re-arm: flush pulse after word 3 of tx=16
//     -> valid low next clk; second run restarts at mem[0]; done clears on flush rise.
//  T6 Edge: tx=0 -> done=1 after WAIT with no valid. Async rst_n mid-stream -> all outputs 0 at once.

Source files
------------

// File: rtl/glb_stream_src.sv
// glb_stream_src: GLB-to-fabric stream source.
// Holds a word image written through a config port. A flush pulse arms the block,
// the falling edge of flush starts the stream, and the stream stops on a word count
// or a done-token count. Optional LFSR-driven bubbles exercise sink-side idle
// handling. A pending word is never withdrawn except by abort or reset.
module glb_stream_src #(
   parameter int                    DATA_WIDTH = 17,
   parameter int                    DEPTH      = 2048,
   parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100,
   parameter logic [15:0]           STALL_MASK = 16'h0003,
   localparam int                   AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  cfg_wr_en,
   input  logic [AW-1:0]         cfg_wr_addr,
   input  logic [DATA_WIDTH-1:0] cfg_wr_data,
   input  logic [AW:0]           cfg_tx_size,
   input  logic [7:0]            cfg_done_num,
   input  logic                  cfg_stall_en,
   input  logic [15:0]           cfg_lfsr_seed,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  done,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT,
      S_STREAM,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  r_flush_d;
   logic [AW:0]           r_tx_size;
   logic [7:0]            r_done_num;
   logic                  r_stall_en;
   logic [15:0]           r_lfsr;
   logic [1:0]            r_wait_cnt;
   logic [AW:0]           r_num_tx;
   logic [7:0]            r_tok_cnt;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_done;

   logic                  w_rise;
   logic                  w_fall;
   logic                  w_busy;
   logic                  w_xfer;
   logic [7:0]            w_tok_nx;
   logic [AW:0]           w_num_nx;
   logic                  w_last;
   logic                  w_need;
   logic                  w_bubble;
   logic                  w_load;
   logic [15:0]           w_lfsr_step;
   logic [15:0]           w_seed;
   logic [AW:0]           w_tx_clamp;
   logic [AW-1:0]         w_idx;

   assign w_rise  = flush & ~r_flush_d;
   assign w_fall  = ~flush & r_flush_d;
   assign w_busy  = (r_state == S_WAIT) || (r_state == S_STREAM);

   // Transfer bookkeeping: next counts as they will be after this edge.
   assign w_xfer   = r_valid && ready && (r_state == S_STREAM);
   assign w_tok_nx = (w_xfer && (r_data == DONE_TOKEN) && (r_tok_cnt != 8'hFF)) ?
                     r_tok_cnt + 8'd1 : r_tok_cnt;
   assign w_num_nx = r_num_tx + {{AW{1'b0}}, w_xfer};
   assign w_last   = w_xfer && ((w_num_nx == r_tx_size) ||
                     ((r_done_num != 8'd0) && (w_tok_nx == r_done_num)));
   assign w_idx    = w_num_nx[AW-1:0];

   // A new word is wanted when nothing is pending (or the pending one leaves now),
   // the stream is not ending and no abort is in flight.
   assign w_need   = (r_state == S_STREAM) && (!r_valid || w_xfer) && !w_last &&
                     !w_rise && (w_num_nx < r_tx_size);
   assign w_bubble = r_stall_en && ((r_lfsr & STALL_MASK) == 16'h0000);
   assign w_load   = w_need && !w_bubble;

   // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
   assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   assign w_seed      = (cfg_lfsr_seed == 16'h0000) ? 16'h0001 : cfg_lfsr_seed;
   assign w_tx_clamp  = (cfg_tx_size > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_tx_size;

   // Image memory; not reset, and frozen while a stream is running.
   always_ff @(posedge clk) begin
      if (cfg_wr_en && !w_busy) r_mem[cfg_wr_addr] <= cfg_wr_data;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   // Next-state logic; an abort (flush rise) outranks stream termination.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_rise) w_state_nx = S_ARMED;
         end
         S_ARMED: begin
            if (w_fall) w_state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (w_rise)                 w_state_nx = S_ARMED;
            else if (r_wait_cnt <= 2'd1) w_state_nx = (r_tx_size == '0) ? S_DONE : S_STREAM;
         end
         S_STREAM: begin
            if (w_rise)      w_state_nx = S_ARMED;
            else if (w_last) w_state_nx = S_DONE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Datapath: config latch, counters, LFSR and the registered output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush_d  <= 1'b0;
         r_tx_size  <= '0;
         r_done_num <= 8'd0;
         r_stall_en <= 1'b0;
         r_lfsr     <= 16'h0001;
         r_wait_cnt <= 2'd0;
         r_num_tx   <= '0;
         r_tok_cnt  <= 8'd0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_flush_d <= flush;
         r_done    <= (w_state_nx == S_DONE);
         if (r_state == S_ARMED && w_fall) begin
            r_tx_size  <= w_tx_clamp;
            r_done_num <= cfg_done_num;
            r_stall_en <= cfg_stall_en;
            r_lfsr     <= w_seed;
            r_num_tx   <= '0;
            r_tok_cnt  <= 8'd0;
            r_wait_cnt <= 2'd3;
         end
         if (r_state == S_WAIT && r_wait_cnt != 2'd0) r_wait_cnt <= r_wait_cnt - 2'd1;
         if (r_state == S_STREAM) begin
            if (w_xfer) begin
               r_num_tx  <= w_num_nx;
               r_tok_cnt <= w_tok_nx;
            end
            if (r_stall_en && w_need) r_lfsr <= w_lfsr_step;
            if (w_load) begin
               r_data  <= r_mem[w_idx];
               r_valid <= 1'b1;
            end else if (w_xfer) begin
               r_valid <= 1'b0;
            end
         end
         // Leaving STREAM for any reason drops the pending word.
         if (w_state_nx != S_STREAM) r_valid <= 1'b0;
      end
   end

   assign data  = r_data;
   assign valid = r_valid;
   assign done  = r_done;
   assign busy  = w_busy;

endmodule
